dct_coef_pingpong: RTL
======================

DCT_COEF_PINGPONG -- requirements
Module: dct_coef_pingpong

Interface
REQ-001 Parameter DATA_W, default 8, coefficient width in bits; legal 8..16.
REQ-002 Parameter N, default 8, block edge (block = N*N coefficients); legal values 4 or 8.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_data holds a coefficient.
REQ-006 in_ready  output  1  block can accept a coefficient this cycle.
REQ-007 in_data  input  DATA_W  coefficient, raster order (row-major).
REQ-008 out_valid  output  1  out_data holds a coefficient.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  DATA_W  coefficient, read order per REQ-030.
REQ-011 out_last  output  1  out_data is the final coefficient of a block.
REQ-012 out_idx  output  $clog2(N*N)  raster index of the coefficient on out_data.

Function
REQ-013 Two banks (0,1) of N*N x DATA_W storage; each bank holds its own state: EMPTY, FILLING, FULL, DRAINING.
REQ-014 Write transfer = in_valid & in_ready; read transfer = out_valid & out_ready.
REQ-015 in_ready = 1 iff write bank is EMPTY or FILLING; purely a function of registered state.
REQ-016 Write transfer: store in_data at wr_cnt in write bank; wr_cnt increments; bank EMPTY->FILLING on first write.
REQ-017 Write with wr_cnt = N*N-1: wr_cnt wraps to 0, bank -> FULL, write-bank pointer toggles.
REQ-018 Read side: when read bank is FULL, it moves to DRAINING; out_valid asserts the cycle after the bank became FULL (minimum latency 1 clock from the last write transfer).
REQ-019 out_data, out_idx, out_last registered; they hold stable while out_valid & !out_ready.
REQ-020 Read transfer: rd_cnt increments; out_last = 1 iff rd_cnt = N*N-1.
REQ-021 Read transfer with out_last: rd_cnt wraps to 0, bank -> EMPTY, read-bank pointer toggles; out_valid deasserts next cycle unless the other bank is FULL, in which case output continues back-to-back with no bubble.
REQ-022 Simultaneous write into one bank and read from the other is permitted every cycle; sustained throughput 1 coefficient/clock.
REQ-023 Both banks FULL/DRAINING: in_ready = 0; in_data ignored regardless of in_valid.
REQ-024 Bank freed (EMPTY) in the same cycle the other bank completes filling: both events applied; no transfer lost.
REQ-025 Data passes unmodified; no arithmetic on coefficients.

Reset
REQ-026 rst sampled on rising clk only; overrides all transfers that cycle.
REQ-027 On rst: both banks EMPTY, wr_cnt = rd_cnt = 0, both pointers = bank 0, out_valid = 0, out_last = 0, out_idx = 0, out_data = 0.
REQ-028 in_ready = 1 in the first cycle after rst deasserts.
REQ-029 rst mid-block discards partial and undrained blocks; storage contents need not be cleared.

Configuration
REQ-030 Macro DCT_COEF_ZIGZAG_EN defined: read order is JPEG zigzag (for N=8, raster indices 0,1,8,16,9,2,...,63); out_idx reports the raster index read. Undefined: read order is raster, out_idx = rd_cnt.

Structure
REQ-031 Package dct_pkg holds the bank-state enum, N*N constants, and the 8x8 and 4x4 zigzag tables.
REQ-032 Sub-module dct_zigzag_rom: combinational map rd_cnt -> raster index, parameter N; instantiated only under DCT_COEF_ZIGZAG_EN.

Verification
REQ-033 Reset then write 0..63 (N=8, out_ready=1) -> out_valid 1 clock after 64th write; raster build emits 0..63; zigzag build emits 0,1,8,16,9,2...; out_last only on 64th.
REQ-034 Stream 3 blocks continuously, out_ready=1 -> in_ready never drops, output gapless, 192 coefficients in order.
REQ-035 out_ready=0 for 200 clocks after 2 blocks written -> in_ready=0 after 128th write; out_data/out_idx stable; release recovers all 128 values.
REQ-036 Toggle out_ready every other clock -> each value appears exactly once, no duplication or loss.
REQ-037 Assert rst after 30 writes, then write block of 0xA5 -> only 64 x 0xA5 emitted; partial block never appears.
REQ-038 N=4, DATA_W=12, write 0x800..0x80F -> 16 outputs, out_last on 16th, out_idx width 4.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared definitions for the DCT coefficient ping-pong buffer:
// bank-state encoding, block sizes and JPEG zigzag scan tables.
package dct_pkg;

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_st_e;

   localparam int BLK_4X4 = 16;
   localparam int BLK_8X8 = 64;

   // Zigzag scan position -> raster index, 8x8 block
   localparam logic [5:0] ZZ8 [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   // Zigzag scan position -> raster index, 4x4 block
   localparam logic [3:0] ZZ4 [16] = '{
      4'd0, 4'd1, 4'd4,  4'd8,  4'd5,  4'd2,  4'd3,  4'd6,
      4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
   };

endpackage

// File: rtl/dct_zigzag_rom.sv
// Combinational zigzag map: read position within a block -> raster index.
module dct_zigzag_rom
   import dct_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [$clog2(N*N)-1:0] pos,
   output logic [$clog2(N*N)-1:0] idx
);

   generate
      if (N == 8) begin : g_8x8
         assign idx = ZZ8[pos];
      end else begin : g_4x4
         assign idx = ZZ4[pos];
      end
   endgenerate

endmodule

// File: rtl/dct_coef_pingpong.sv
// Two-bank ping-pong buffer for DCT coefficient blocks. Blocks are written
// in raster order into one bank while the other drains to a registered
// output stage. Define DCT_COEF_ZIGZAG_EN to drain in JPEG zigzag order;
// otherwise blocks drain in raster order.
module dct_coef_pingpong
   import dct_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int N      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_last,
   output logic [$clog2(N*N)-1:0]    out_idx
);

   localparam int NN = (N == 8) ? BLK_8X8 : BLK_4X4;
   localparam int AW = $clog2(NN);
   localparam logic [AW-1:0] LAST = AW'(NN - 1);

   bank_st_e          st [2];
   bank_st_e          st_nxt [2];
   logic              wr_ptr, rd_ptr;
   logic [AW-1:0]     wr_cnt, rd_cnt;
   logic [DATA_W-1:0] mem [2*NN];

   logic              wr_fire, wr_done, rd_fire, rd_done;
   logic              avail [2];
   logic              load, load_b;
   logic [AW-1:0]     load_pos, load_idx;

   logic              vld_p1, last_p1;
   logic [DATA_W-1:0] data_p1;
   logic [AW-1:0]     idx_p1;

   assign in_ready = (st[wr_ptr] == BANK_EMPTY) || (st[wr_ptr] == BANK_FILLING);
   assign wr_fire  = in_valid & in_ready;
   assign wr_done  = wr_fire && (wr_cnt == LAST);
   assign rd_fire  = vld_p1 & out_ready;
   assign rd_done  = rd_fire & last_p1;

`ifdef DCT_COEF_ZIGZAG_EN
   dct_zigzag_rom #(.N(N)) u_zz (
      .pos (load_pos),
      .idx (load_idx)
   );
`else
   assign load_idx = load_pos;
`endif

   // A bank can start draining if it is full or completes filling this cycle
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         avail[b] = (st[b] == BANK_FULL) || (wr_done && (wr_ptr == 1'(b)));
      end
   end

   // Pick what the output stage loads next: first of a bank, or next in bank
   always_comb begin
      load     = 1'b0;
      load_b   = rd_ptr;
      load_pos = '0;
      if (!vld_p1) begin
         load = avail[rd_ptr];
      end else if (rd_fire && !last_p1) begin
         load     = 1'b1;
         load_pos = rd_cnt + AW'(1);
      end else if (rd_done) begin
         load_b = ~rd_ptr;
         load   = avail[~rd_ptr];
      end
   end

   // Per-bank state transitions; fill and drain events may hit both banks at once
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         st_nxt[b] = st[b];
         if (wr_fire && (wr_ptr == 1'(b)))
            st_nxt[b] = wr_done ? BANK_FULL : BANK_FILLING;
         if (load && (load_b == 1'(b)))
            st_nxt[b] = BANK_DRAINING;
         if (rd_done && (rd_ptr == 1'(b)))
            st_nxt[b] = BANK_EMPTY;
      end
   end

   // Bank states, pointers and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         st[0]  <= BANK_EMPTY;
         st[1]  <= BANK_EMPTY;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         st <= st_nxt;
         if (wr_fire)
            wr_cnt <= wr_done ? '0 : wr_cnt + AW'(1);
         if (wr_done)
            wr_ptr <= ~wr_ptr;
         if (rd_done)
            rd_ptr <= ~rd_ptr;
         if (load)
            rd_cnt <= load_pos;
         else if (rd_done)
            rd_cnt <= '0;
      end
   end

   // Coefficient storage; contents survive reset
   always_ff @(posedge clk) begin
      if (!rst && wr_fire)
         mem[{wr_ptr, wr_cnt}] <= in_data;
   end

   // ---- stage p1: registered output, held while downstream stalls ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         data_p1 <= '0;
         idx_p1  <= '0;
      end else if (load) begin
         vld_p1  <= 1'b1;
         last_p1 <= (load_pos == LAST);
         data_p1 <= mem[{load_b, load_idx}];
         idx_p1  <= load_idx;
      end else if (rd_fire) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_last  = last_p1;
   assign out_idx   = idx_p1;

endmodule
